// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : Bundles the issue-request handshake from the load-store queue and
//           the one-cycle writeback bus to the ROB/CDB for mem_access_unit.
// Signals :
//   in_valid / in_ready      issue handshake (ready = request FIFO not full)
//   in_pc, in_address        instruction PC and effective byte address
//   in_rob_num, in_dest_reg  ROB tag and physical destination register
//   in_load_store, in_size   0 load / 1 store, 0 word / 1 byte
//   in_sw_data               store data
//   in_from_lsq, in_lw_data  load already satisfied by LSQ forwarding + its data
//   wb_valid                 one-cycle completion pulse
//   wb_pc, wb_rob_num        PC and ROB tag of the completed op
//   wb_dest_reg, wb_data     destination and load result (0 for stores)
//   wb_is_store              completed op was a store
//   wb_misaligned            word op whose address[1:0] was non-zero
// Modports: master = upstream issuer / ROB side, slave = mem_access_unit.
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_address;
    logic [5:0]  in_rob_num;
    logic [5:0]  in_dest_reg;
    logic        in_load_store;
    logic        in_size;
    logic [31:0] in_sw_data;
    logic        in_from_lsq;
    logic [31:0] in_lw_data;

    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [5:0]  wb_rob_num;
    logic [5:0]  wb_dest_reg;
    logic [31:0] wb_data;
    logic        wb_is_store;
    logic        wb_misaligned;

    modport master (
        output in_valid, in_pc, in_address, in_rob_num, in_dest_reg,
               in_load_store, in_size, in_sw_data, in_from_lsq, in_lw_data,
        input  in_ready,
        input  wb_valid, wb_pc, wb_rob_num, wb_dest_reg, wb_data,
               wb_is_store, wb_misaligned
    );

    modport slave (
        input  in_valid, in_pc, in_address, in_rob_num, in_dest_reg,
               in_load_store, in_size, in_sw_data, in_from_lsq, in_lw_data,
        output in_ready,
        output wb_valid, wb_pc, wb_rob_num, wb_dest_reg, wb_data,
               wb_is_store, wb_misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Purpose : Data-memory stage behind the load-store queue. Issued loads/stores
//           are buffered in order in a small FIFO, then executed one at a time
//           against a byte-addressed little-endian memory with a fixed
//           multi-cycle latency. Each completion produces a one-cycle
//           writeback pulse. Loads already satisfied by LSQ forwarding skip
//           the memory array but still retire in program order.
// Ports   :
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (control and writeback only)
//   bus   slave modport of mem_access_unit_if (issue + writeback)
//   busy  out  an op is in flight or the FIFO holds requests
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_BYTES  = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus,
    output logic             busy
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] address;
        logic [5:0]  rob_num;
        logic [5:0]  dest_reg;
        logic        load_store;
        logic        size;
        logic [31:0] sw_data;
        logic        from_lsq;
        logic [31:0] lw_data;
    } req_t;

    typedef enum logic {IDLE, BUSY} state_t;

    // LB semantics: the byte is treated as signed and widened.
    function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
        return 32'(b);
    endfunction

    // FIFO storage and pointers
    req_t            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            push;
    logic            pop;
    req_t            in_req;
    req_t            head_p0;

    // FSM and the op currently being executed
    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            complete;
    req_t            op_p1;

    // Data memory; deliberately not reset
    logic [7:0]      mem [MEM_BYTES];

    logic [AW-1:0]   byte_idx;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic [31:0]     ld_data;
    logic            misaligned;
    logic            unused_addr_bits;

    always_comb begin
        in_req            = '0;
        in_req.pc         = bus.in_pc;
        in_req.address    = bus.in_address;
        in_req.rob_num    = bus.in_rob_num;
        in_req.dest_reg   = bus.in_dest_reg;
        in_req.load_store = bus.in_load_store;
        in_req.size       = bus.in_size;
        in_req.sw_data    = bus.in_sw_data;
        in_req.from_lsq   = bus.in_from_lsq;
        in_req.lw_data    = bus.in_lw_data;
    end

    // Ready depends only on occupancy: a pop on the same edge does not free a
    // slot for the incoming request.
    assign bus.in_ready = (count != (PW + 1)'(FIFO_DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign head_p0      = fifo_mem[rd_ptr];

    // ---- stage 0: request FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- stage 1: execute FSM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    cnt_d   = head_p0.from_lsq ? CW'(1) : CW'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            op_p1 <= head_p0;
        end
    end

    // Addresses wrap modulo the memory size; word accesses ignore address[1:0].
    assign byte_idx         = op_p1.address[AW-1:0];
    assign word_idx         = {byte_idx[AW-1:2], 2'b00};
    assign unused_addr_bits = ^op_p1.address[31:AW];
    assign misaligned       = ~op_p1.size & (op_p1.address[1:0] != 2'b00);
    assign rd_word          = {mem[{byte_idx[AW-1:2], 2'd3}],
                               mem[{byte_idx[AW-1:2], 2'd2}],
                               mem[{byte_idx[AW-1:2], 2'd1}],
                               mem[word_idx]};

    always_comb begin
        ld_data = '0;
        if (op_p1.from_lsq) begin
            ld_data = op_p1.size ? sext_byte(op_p1.lw_data[7:0]) : op_p1.lw_data;
        end else begin
            ld_data = op_p1.size ? sext_byte(mem[byte_idx]) : rd_word;
        end
    end

    // Stores commit on the completion edge, so any later load already queued
    // behind them sees the new data.
    always_ff @(posedge clk) begin
        if (complete && op_p1.load_store) begin
            if (op_p1.size) begin
                mem[byte_idx] <= op_p1.sw_data[7:0];
            end else begin
                mem[word_idx]                    <= op_p1.sw_data[7:0];
                mem[{byte_idx[AW-1:2], 2'd1}]    <= op_p1.sw_data[15:8];
                mem[{byte_idx[AW-1:2], 2'd2}]    <= op_p1.sw_data[23:16];
                mem[{byte_idx[AW-1:2], 2'd3}]    <= op_p1.sw_data[31:24];
            end
        end
    end

    // ---- stage 2: writeback register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_pc         <= '0;
            bus.wb_rob_num    <= '0;
            bus.wb_dest_reg   <= '0;
            bus.wb_data       <= '0;
            bus.wb_is_store   <= 1'b0;
            bus.wb_misaligned <= 1'b0;
        end else begin
            bus.wb_valid <= complete;
            if (complete) begin
                bus.wb_pc         <= op_p1.pc;
                bus.wb_rob_num    <= op_p1.rob_num;
                bus.wb_dest_reg   <= op_p1.load_store ? 6'd0 : op_p1.dest_reg;
                bus.wb_data       <= op_p1.load_store ? 32'd0 : ld_data;
                bus.wb_is_store   <= op_p1.load_store;
                bus.wb_misaligned <= misaligned;
            end
        end
    end

    assign busy = (state_q != IDLE) | (count != '0);

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit. Requests are issued through the
// interface; each expected writeback is computed from a byte-level reference
// memory when the request is accepted and queued, then popped and compared
// whenever the unit pulses wb_valid.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    localparam int MB  = 1024;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;
    int   cyc;
    int   wb_count;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .MEM_BYTES (MB),
        .LATENCY   (LAT),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [31:0] data;
        logic        st;
        logic        mis;
        int          exp_cyc;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] model_mem [MB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (bus.wb_valid === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL wb_unexpected observed=pulse pc=0x%08h expected=no_pulse", bus.wb_pc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                wb_count++;
                chk("wb_pc", bus.wb_pc, e.pc);
                chk("wb_rob_num", 32'(bus.wb_rob_num), 32'(e.rob));
                chk("wb_dest_reg", 32'(bus.wb_dest_reg), 32'(e.dest));
                chk("wb_data", bus.wb_data, e.data);
                chk("wb_is_store", 32'(bus.wb_is_store), 32'(e.st));
                chk("wb_misaligned", 32'(bus.wb_misaligned), 32'(e.mis));
                if (e.exp_cyc >= 0) begin
                    chk("wb_latency_cycle", 32'(cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    // Issue one request; lat < 0 means the writeback cycle is not checked,
    // otherwise it is the number of edges from acceptance to the wb pulse.
    task automatic send(input logic [31:0] pc, input logic [31:0] addr,
                        input logic [5:0] rob, input logic [5:0] dest,
                        input logic st, input logic sz, input logic [31:0] swd,
                        input logic fl, input logic [31:0] lwd,
                        input bit expect_wb, input int lat, output int waits);
        exp_t       e;
        int         idx;
        int         widx;
        logic [7:0] b;
        bus.in_valid      = 1'b1;
        bus.in_pc         = pc;
        bus.in_address    = addr;
        bus.in_rob_num    = rob;
        bus.in_dest_reg   = dest;
        bus.in_load_store = st;
        bus.in_size       = sz;
        bus.in_sw_data    = swd;
        bus.in_from_lsq   = fl;
        bus.in_lw_data    = lwd;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout observed=0 expected=1");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "in_ready never asserted");
        end
        idx   = int'(addr[9:0]);
        widx  = idx & 1020;
        e.pc  = pc;
        e.rob = rob;
        e.st  = st;
        e.mis = !sz && (addr[1:0] != 2'b00);
        if (st) begin
            e.dest = 6'd0;
            e.data = 32'd0;
            if (expect_wb) begin
                if (sz) begin
                    model_mem[idx] = swd[7:0];
                end else begin
                    model_mem[widx]     = swd[7:0];
                    model_mem[widx + 1] = swd[15:8];
                    model_mem[widx + 2] = swd[23:16];
                    model_mem[widx + 3] = swd[31:24];
                end
            end
        end else begin
            e.dest = dest;
            if (fl) begin
                e.data = sz ? {{24{lwd[7]}}, lwd[7:0]} : lwd;
            end else if (sz) begin
                b      = model_mem[idx];
                e.data = {{24{b[7]}}, b};
            end else begin
                e.data = {model_mem[widx + 3], model_mem[widx + 2],
                          model_mem[widx + 1], model_mem[widx]};
            end
        end
        @(posedge clk);
        #1;
        e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
        if (expect_wb) sb_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("drain_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int stall_total;
        int wb_before;
        checks   = 0;
        failures = 0;
        wb_count = 0;
        for (int i = 0; i < MB; i++) model_mem[i] = 8'h00;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_address    = '0;
        bus.in_rob_num    = '0;
        bus.in_dest_reg   = '0;
        bus.in_load_store = 1'b0;
        bus.in_size       = 1'b0;
        bus.in_sw_data    = '0;
        bus.in_from_lsq   = 1'b0;
        bus.in_lw_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store word then dependent load word
        send(32'h100, 32'h10, 6'd1, 6'd9, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, LAT + 1, w);
        send(32'h104, 32'h10, 6'd2, 6'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2 * LAT + 1, w);
        drain();
        chk("wb_hold_data", bus.wb_data, 32'hDEADBEEF);
        chk("wb_hold_valid_low", 32'(bus.wb_valid), 32'd0);

        // Byte store over the word, byte load (sign-extended), word reload
        send(32'h108, 32'h13, 6'd3, 6'd0, 1'b1, 1'b1, 32'hABCDEF80, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h10C, 32'h13, 6'd4, 6'd4, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h110, 32'h10, 6'd6, 6'd5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
        drain();

        // Forwarded loads bypass memory (address 0x10 holds 0x80ADBEEF)
        send(32'h114, 32'h10, 6'd5, 6'd7, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1, 2, w);
        drain();
        send(32'h118, 32'h10, 6'd7, 6'd8, 1'b0, 1'b1, 32'h0, 1'b1, 32'h000000F0, 1'b1, 2, w);
        drain();

        // Address wrap and misalignment
        send(32'h11C, 32'h400, 6'd8, 6'd0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h120, 32'h402, 6'd9, 6'd10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h124, 32'h401, 6'd10, 6'd11, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h128, 32'h406, 6'd11, 6'd0, 1'b1, 1'b0, 32'h01020304, 1'b0, 32'h0, 1'b1, -1, w);
        send(32'h12C, 32'h004, 6'd12, 6'd12, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
        drain();

        // Back-to-back burst: must back-pressure without losing requests
        stall_total = 0;
        wb_before   = wb_count;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) begin
                send(32'h200 + 32'(4 * i), 32'h40 + 32'(4 * i), 6'(20 + i), 6'd0, 1'b1, 1'b0,
                     32'h11111111 * 32'(i + 1), 1'b0, 32'h0, 1'b1, -1, w);
            end else begin
                send(32'h200 + 32'(4 * i), 32'h40 + 32'(4 * (i - 1)), 6'(20 + i), 6'(30 + i),
                     1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, -1, w);
            end
            stall_total += w;
        end
        drain();
        chk("burst_backpressure_seen", 32'(stall_total > 0), 32'd1);
        chk("burst_wb_count", 32'(wb_count - wb_before), 32'd7);

        // Reset during an in-flight store drops it
        send(32'h300, 32'h20, 6'd40, 6'd0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h0, 1'b1, -1, w);
        drain();
        send(32'h304, 32'h20, 6'd41, 6'd0, 1'b1, 1'b1, 32'h00000055, 1'b0, 32'h0, 1'b0, -1, w);
        @(posedge clk);
        #1;
        chk("inflight_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_reset_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("async_reset_wb_pc", bus.wb_pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(32'h308, 32'h20, 6'd42, 6'd13, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, LAT + 1, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
